// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the data-memory port arbiter and its requesters plus the Data_MEM port.
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned Address_Width = 32,
    parameter int unsigned Word_Width    = 32
);
    logic                     req0_valid;
    logic                     req0_ready;
    logic                     req0_we;
    logic [Address_Width-1:0] req0_addr;
    logic [Word_Width-1:0]    req0_wdata;
    logic [2:0]               req0_funct3;
    logic                     rsp0_valid;
    logic [Word_Width-1:0]    rsp0_rdata;
    logic                     rsp0_err;

    logic                     req1_valid;
    logic                     req1_ready;
    logic                     req1_we;
    logic [Address_Width-1:0] req1_addr;
    logic [Word_Width-1:0]    req1_wdata;
    logic [2:0]               req1_funct3;
    logic                     rsp1_valid;
    logic [Word_Width-1:0]    rsp1_rdata;
    logic                     rsp1_err;

    logic                     mem_we;
    logic [Address_Width-1:0] mem_addr;
    logic [Word_Width-1:0]    mem_wdata;
    logic [2:0]               mem_funct3;
    logic [Word_Width-1:0]    mem_rdata;

    logic                     busy;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_funct3,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_funct3,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_we, mem_addr, mem_wdata, mem_funct3,
        output busy
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_funct3,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_funct3,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_we, mem_addr, mem_wdata, mem_funct3,
        input  busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single Data_MEM port: port 0 has fixed priority,
// a starvation counter forces a port-1 grant, misaligned accesses are trapped.
module dmem_port_arbiter #(
    parameter int unsigned Address_Width = 32,
    parameter int unsigned Word_Width    = 32,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);
    localparam int unsigned AW = Address_Width;
    localparam int unsigned WW = Word_Width;
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        logic [2:0]    funct3;
        logic          mis;
    } req_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] starve_cnt;
    req_t          lat;

    logic          acc0_c;
    logic          acc1_c;
    logic          accept_c;
    logic          starved_c;
    logic          sel_we_c;
    logic [AW-1:0] sel_addr_c;
    logic [WW-1:0] sel_wdata_c;
    logic [2:0]    sel_funct3_c;
    logic          sel_mis_c;
    logic [WW-1:0] rdata_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state and grant: port 0 wins unless port 1 has waited STARVE_LIMIT grants.
    always_comb begin
        state_nx  = state;
        acc0_c    = 1'b0;
        acc1_c    = 1'b0;
        starved_c = (starve_cnt == CW'(STARVE_LIMIT));
        case (state)
            IDLE, RESP: begin
                if (bus.req0_valid && (!bus.req1_valid || !starved_c)) acc0_c = 1'b1;
                else if (bus.req1_valid)                             acc1_c = 1'b1;
                state_nx = (acc0_c || acc1_c) ? ACCESS : IDLE;
            end
            ACCESS:  state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req0_ready = acc0_c;
    assign bus.req1_ready = acc1_c;
    assign accept_c       = acc0_c || acc1_c;

    assign sel_we_c     = acc1_c ? bus.req1_we     : bus.req0_we;
    assign sel_addr_c   = acc1_c ? bus.req1_addr   : bus.req0_addr;
    assign sel_wdata_c  = acc1_c ? bus.req1_wdata  : bus.req0_wdata;
    assign sel_funct3_c = acc1_c ? bus.req1_funct3 : bus.req0_funct3;
    assign sel_mis_c    = ((sel_funct3_c[1:0] == 2'b01) && sel_addr_c[0]) ||
                          ((sel_funct3_c == 3'b010) && (sel_addr_c[1:0] != 2'b00));

    // Stores and trapped accesses return zero data.
    assign rdata_c = (lat.we || lat.mis) ? '0 : bus.mem_rdata;

    assign bus.mem_addr   = lat.addr;
    assign bus.mem_wdata  = lat.wdata;
    assign bus.mem_funct3 = lat.funct3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat            <= '0;
            starve_cnt     <= '0;
            bus.mem_we     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp0_rdata <= '0;
            bus.rsp0_err   <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp1_rdata <= '0;
            bus.rsp1_err   <= 1'b0;
        end else begin
            bus.busy   <= (state_nx != IDLE);
            // Write enable is live only for the single ACCESS cycle after an accept.
            bus.mem_we <= accept_c && sel_we_c && !sel_mis_c;
            if (accept_c) begin
                lat <= '{port: acc1_c, we: sel_we_c, addr: sel_addr_c, wdata: sel_wdata_c,
                         funct3: sel_funct3_c, mis: sel_mis_c};
            end

            bus.rsp0_valid <= (state == ACCESS) && !lat.port;
            bus.rsp0_rdata <= ((state == ACCESS) && !lat.port) ? rdata_c : '0;
            bus.rsp0_err   <= (state == ACCESS) && !lat.port && lat.mis;
            bus.rsp1_valid <= (state == ACCESS) && lat.port;
            bus.rsp1_rdata <= ((state == ACCESS) && lat.port) ? rdata_c : '0;
            bus.rsp1_err   <= (state == ACCESS) && lat.port && lat.mis;

            if (acc1_c || !bus.req1_valid) begin
                starve_cnt <= '0;
            end else if (acc0_c && (starve_cnt != CW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a transaction-level model
// with its own shadow memory; a small byte-array memory stands in for Data_MEM.
module tb_dmem_port_arbiter;
    localparam int unsigned AW    = 32;
    localparam int unsigned WW    = 32;
    localparam int unsigned LIMIT = 4;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        bit          mis;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.Address_Width(AW), .Word_Width(WW)) bus ();

    dmem_port_arbiter #(.Address_Width(AW), .Word_Width(WW), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] ld_val(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [2:0] f3);
        case (f3)
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {{24{b0[7]}}, b0};
        endcase
    endfunction

    function automatic int st_len(input logic [2:0] f3);
        if (f3 == 3'b001) return 2;
        if (f3 == 3'b010) return 4;
        return 1;
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [2:0] f3);
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
        if (f3 == 3'b010)                 return (a % 4) != 0;
        return 1'b0;
    endfunction

    // Data_MEM stand-in: combinational read, write on the clock edge.
    logic [7:0] env_mem [256];
    logic [7:0] ea;
    assign ea = bus.mem_addr[7:0];
    always_comb bus.mem_rdata = ld_val(env_mem[ea], env_mem[8'(ea + 8'd1)],
                                       env_mem[8'(ea + 8'd2)], env_mem[8'(ea + 8'd3)],
                                       bus.mem_funct3);
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
        end else if (bus.mem_we) begin
            for (int i = 0; i < st_len(bus.mem_funct3); i++)
                env_mem[8'(ea + 8'(i))] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [256];
    bit          in_access, in_resp;
    txn_t        acc_txn, resp_txn;
    int          streak;
    bit          h_valid [2];
    txn_t        h_txn [2];
    bit          refill [2];
    bit          rand_mode;
    int          n_chk, n_fail, cyc, we_seen;
    logic [31:0] last_rdata [2];
    bit          last_err [2];
    int          acc_port_q [$];
    int          acc_cyc_q [$];
    logic [2:0]  f3tab [7];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic txn_t rand_txn(input bit p);
        txn_t t;
        t.port  = p;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = 32'($urandom_range(0, 63));
        t.wdata = $urandom;
        t.f3    = f3tab[$urandom_range(0, 6)];
        t.mis   = 1'b0;
        t.rdata = '0;
        return t;
    endfunction

    function automatic txn_t mk_txn(input bit p, input bit we, input logic [31:0] a,
                                    input logic [31:0] d, input logic [2:0] f3);
        txn_t t;
        t.port = p; t.we = we; t.addr = a; t.wdata = d; t.f3 = f3; t.mis = 1'b0; t.rdata = '0;
        return t;
    endfunction

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (!h_valid[p] && refill[p]) begin
                h_txn[p]   = mk_txn(1'(p), 1'b0, 32'(4 * $urandom_range(0, 15)), '0, 3'b010);
                h_valid[p] = 1'b1;
            end else if (!h_valid[p] && rand_mode && $urandom_range(0, 2) == 0) begin
                h_txn[p]   = rand_txn(1'(p));
                h_valid[p] = 1'b1;
            end
        end
        bus.req0_valid = h_valid[0]; bus.req0_we = h_txn[0].we; bus.req0_addr = h_txn[0].addr;
        bus.req0_wdata = h_txn[0].wdata; bus.req0_funct3 = h_txn[0].f3;
        bus.req1_valid = h_valid[1]; bus.req1_we = h_txn[1].we; bus.req1_addr = h_txn[1].addr;
        bus.req1_wdata = h_txn[1].wdata; bus.req1_funct3 = h_txn[1].f3;
    endtask

    // Registered outputs for the current cycle, from the model's pipeline position.
    task automatic check_regs();
        bit r0, r1;
        r0 = in_resp && !resp_txn.port;
        r1 = in_resp && resp_txn.port;
        check_eq("busy", 32'(bus.busy), 32'(in_access || in_resp));
        check_eq("mem_we", 32'(bus.mem_we), 32'(in_access && acc_txn.we && !acc_txn.mis));
        if (in_access) begin
            check_eq("mem_addr", bus.mem_addr, acc_txn.addr);
            check_eq("mem_wdata", bus.mem_wdata, acc_txn.wdata);
            check_eq("mem_funct3", 32'(bus.mem_funct3), 32'(acc_txn.f3));
        end
        check_eq("rsp0_valid", 32'(bus.rsp0_valid), 32'(r0));
        check_eq("rsp0_rdata", bus.rsp0_rdata, r0 ? resp_txn.rdata : 32'h0);
        check_eq("rsp0_err", 32'(bus.rsp0_err), 32'(r0 && resp_txn.mis));
        check_eq("rsp1_valid", 32'(bus.rsp1_valid), 32'(r1));
        check_eq("rsp1_rdata", bus.rsp1_rdata, r1 ? resp_txn.rdata : 32'h0);
        check_eq("rsp1_err", 32'(bus.rsp1_err), 32'(r1 && resp_txn.mis));
        if (bus.rsp0_valid) begin last_rdata[0] = bus.rsp0_rdata; last_err[0] = bus.rsp0_err; end
        if (bus.rsp1_valid) begin last_rdata[1] = bus.rsp1_rdata; last_err[1] = bus.rsp1_err; end
        if (bus.mem_we) we_seen++;
    endtask

    task automatic step();
        bit v0, v1, e0, e1;
        int p;
        @(negedge clk);
        check_regs();
        drive();
        #1;
        v0 = h_valid[0];
        v1 = h_valid[1];
        e0 = !in_access && v0 && (!v1 || streak != LIMIT);
        e1 = !in_access && v1 && (!v0 || streak == LIMIT);
        check_eq("ready0", 32'(bus.req0_ready), 32'(e0));
        check_eq("ready1", 32'(bus.req1_ready), 32'(e1));
        check_eq("both_ready", 32'(bus.req0_ready & bus.req1_ready), 32'h0);
        if (bus.req0_valid && bus.req0_ready) begin acc_port_q.push_back(0); acc_cyc_q.push_back(cyc); end
        if (bus.req1_valid && bus.req1_ready) begin acc_port_q.push_back(1); acc_cyc_q.push_back(cyc); end

        // Upcoming edge: finish the in-flight access, then take the new request.
        if (in_access) begin
            if (acc_txn.we && !acc_txn.mis)
                for (int i = 0; i < st_len(acc_txn.f3); i++)
                    ref_mem[8'(acc_txn.addr[7:0] + 8'(i))] = acc_txn.wdata[8*i +: 8];
            acc_txn.rdata = (acc_txn.we || acc_txn.mis) ? 32'h0 :
                ld_val(ref_mem[acc_txn.addr[7:0]], ref_mem[8'(acc_txn.addr[7:0] + 8'd1)],
                       ref_mem[8'(acc_txn.addr[7:0] + 8'd2)], ref_mem[8'(acc_txn.addr[7:0] + 8'd3)],
                       acc_txn.f3);
        end
        in_resp  = in_access;
        resp_txn = acc_txn;
        if (e0 || e1) begin
            p          = e1 ? 1 : 0;
            acc_txn    = h_txn[p];
            acc_txn.mis = is_mis(acc_txn.addr, acc_txn.f3);
            in_access  = 1'b1;
            h_valid[p] = 1'b0;
        end else begin
            in_access = 1'b0;
        end
        if (!v1 || e1)  streak = 0;
        else if (e0)    streak = (streak < LIMIT) ? streak + 1 : LIMIT;
        cyc++;
    endtask

    task automatic issue(input bit p, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3);
        h_txn[p]   = mk_txn(p, we, a, d, f3);
        h_valid[p] = 1'b1;
        for (int k = 0; k < 20 && h_valid[p]; k++) step();
        check_eq("accept_timeout", 32'(h_valid[p]), 32'h0);
        h_valid[p] = 1'b0;
    endtask

    task automatic drain();
        refill[0] = 1'b0; refill[1] = 1'b0; rand_mode = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!h_valid[0] && !h_valid[1] && !in_access && !in_resp) break;
            step();
        end
        check_eq("drain_timeout", 32'(h_valid[0] | h_valid[1] | in_access | in_resp), 32'h0);
        step();
    endtask

    task automatic load_check(input string tag, input bit p, input logic [31:0] a,
                              input logic [2:0] f3, input logic [31:0] exp, input bit exp_err);
        last_rdata[p] = 32'hBAD0_BAD0;
        last_err[p]   = 1'b0;
        issue(p, 1'b0, a, 32'h0, f3);
        step();
        step();
        check_eq({tag, "_rdata"}, last_rdata[p], exp);
        check_eq({tag, "_err"}, 32'(last_err[p]), 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [10];
        int base;
        f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        n_chk = 0; n_fail = 0; cyc = 0; we_seen = 0; streak = 0;
        in_access = 1'b0; in_resp = 1'b0; rand_mode = 1'b0;
        for (int p = 0; p < 2; p++) begin
            h_valid[p] = 1'b0; refill[p] = 1'b0; h_txn[p] = mk_txn(1'(p), 1'b0, '0, '0, '0);
        end
        acc_txn = h_txn[0]; resp_txn = h_txn[0];
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        drive();
        repeat (2) @(posedge clk);
        mem_clr = 1'b0;
        #2;
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Store/load word round trip
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        load_check("t1_lw", 1'b0, 32'h10, 3'b010, 32'hDEADBEEF, 1'b0);

        // Byte store with signed and unsigned reload
        issue(1'b0, 1'b1, 32'h21, 32'h00000080, 3'b000);
        load_check("t2_lb", 1'b0, 32'h21, 3'b000, 32'hFFFFFF80, 1'b0);
        load_check("t2_lbu", 1'b0, 32'h21, 3'b100, 32'h00000080, 1'b0);

        // Misaligned accesses trap, never write
        we_seen = 0;
        load_check("t4_lh", 1'b0, 32'h03, 3'b001, 32'h0, 1'b1);
        load_check("t4_sw", 1'b0, 32'h06, 3'b010, 32'h0, 1'b1);
        check_eq("t4_no_we", 32'(we_seen), 32'h0);
        load_check("t4_mem", 1'b1, 32'h04, 3'b010, 32'h0, 1'b0);
        drain();

        // Continuous contention: starvation limit forces port 1 through
        acc_port_q.delete(); acc_cyc_q.delete();
        refill[0] = 1'b1; refill[1] = 1'b1;
        repeat (24) step();
        drain();
        check_eq("t3_count", 32'(acc_port_q.size() >= 10), 32'h1);
        for (int i = 0; i < 10 && i < acc_port_q.size(); i++)
            check_eq($sformatf("t3_order%0d", i), 32'(acc_port_q[i]), 32'(exp_order[i]));

        // Port 1 back-to-back loads: one accept every two cycles
        acc_port_q.delete(); acc_cyc_q.delete();
        refill[1] = 1'b1;
        repeat (12) step();
        drain();
        check_eq("t5_count", 32'(acc_cyc_q.size() >= 5), 32'h1);
        for (int i = 1; i < acc_cyc_q.size(); i++)
            check_eq("t5_spacing", 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd2);

        // Reset during the ACCESS cycle of a store
        issue(1'b0, 1'b1, 32'h40, 32'h12345678, 3'b010);
        @(posedge clk);
        #2;
        check_eq("t6_we_pre", 32'(bus.mem_we), 32'h1);
        rst = 1'b0;
        #1;
        check_eq("t6_busy", 32'(bus.busy), 32'h0);
        check_eq("t6_mem_we", 32'(bus.mem_we), 32'h0);
        check_eq("t6_mem_addr", bus.mem_addr, 32'h0);
        check_eq("t6_mem_wdata", bus.mem_wdata, 32'h0);
        check_eq("t6_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err}), 32'h0);
        in_access = 1'b0; in_resp = 1'b0; streak = 0;
        drive();
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_rsp_hold", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'h0);
        rst = 1'b1;
        step();
        load_check("t6_lw", 1'b0, 32'h40, 3'b010, 32'h0, 1'b0);

        // Random traffic on both ports
        rand_mode = 1'b1;
        base = n_chk;
        repeat (400) step();
        drain();
        check_eq("rand_ran", 32'(n_chk > base), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
